// File: rtl/fsk_tx_ctrl.sv
// fsk_tx_ctrl: byte-to-bit framing controller sequencing the FSK modulator.
// Frames each byte as [preamble] start, 8 data bits LSB-first, stop.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   data_in      byte to send, sampled on valid && ready
//   valid/ready  upstream byte handshake
//   abort        synchronous abort of the current frame/burst
//   x_out        modulator bit select (1 = mark, 0 = space)
//   tx_en        high while a frame is on air
//   busy         high in any state except IDLE
//   bit_strobe   one-cycle pulse on the first cycle of every bit
module fsk_tx_ctrl #(
    parameter int BIT_CYCLES    = 40,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    input  logic       abort,
    output logic       x_out,
    output logic       tx_en,
    output logic       busy,
    output logic       bit_strobe
);

    localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW = (PREAMBLE_BITS > 2) ? $clog2(PREAMBLE_BITS) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_PEN  = CW'(BIT_CYCLES - 2);
    localparam logic [PW-1:0] PRE_LAST =
        PW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam bit HAS_PRE = (PREAMBLE_BITS > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cyc, cyc_d;
    logic [PW-1:0] pcnt, pcnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic          x_d, tx_en_d, busy_d, ready_d, strobe_d;

    logic bit_end;
    logic hs;

    assign bit_end = (cyc == CYC_LAST);
    assign hs      = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cyc        <= '0;
            pcnt       <= '0;
            idx        <= '0;
            shift      <= '0;
            x_out      <= 1'b1;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            state      <= state_d;
            cyc        <= cyc_d;
            pcnt       <= pcnt_d;
            idx        <= idx_d;
            shift      <= shift_d;
            x_out      <= x_d;
            tx_en      <= tx_en_d;
            busy       <= busy_d;
            ready      <= ready_d;
            bit_strobe <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state;
        pcnt_d   = pcnt;
        idx_d    = idx;
        shift_d  = shift;
        x_d      = x_out;
        tx_en_d  = tx_en;
        busy_d   = busy;
        ready_d  = ready;
        strobe_d = 1'b0;
        cyc_d    = '0;

        if (state != S_IDLE) begin
            cyc_d = bit_end ? '0 : cyc + CW'(1);
        end

        unique case (state)
            S_IDLE: begin
                x_d     = 1'b1;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                pcnt_d  = '0;
                idx_d   = '0;
                if (hs) begin
                    shift_d  = data_in;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    tx_en_d  = 1'b1;
                    strobe_d = 1'b1;
                    if (HAS_PRE) begin
                        state_d = S_PREAMBLE;
                        x_d     = 1'b1;
                    end else begin
                        state_d = S_START;
                        x_d     = 1'b0;
                    end
                end
            end

            S_PREAMBLE: begin
                if (bit_end) begin
                    strobe_d = 1'b1;
                    if (pcnt == PRE_LAST) begin
                        state_d = S_START;
                        x_d     = 1'b0;
                    end else begin
                        // preamble bit k is 1 for even k
                        pcnt_d = pcnt + PW'(1);
                        x_d    = pcnt[0];
                    end
                end
            end

            S_START: begin
                if (bit_end) begin
                    strobe_d = 1'b1;
                    state_d  = S_DATA;
                    idx_d    = '0;
                    x_d      = shift[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    strobe_d = 1'b1;
                    shift_d  = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
                        state_d = S_STOP;
                        x_d     = 1'b1;
                    end else begin
                        idx_d = idx + 3'd1;
                        x_d   = shift[1];
                    end
                end
            end

            S_STOP: begin
                // registered ready lands on the final STOP cycle only
                if (cyc == CYC_PEN) begin
                    ready_d = 1'b1;
                end
                if (bit_end) begin
                    if (hs) begin
                        shift_d  = data_in;
                        ready_d  = 1'b0;
                        strobe_d = 1'b1;
                        state_d  = S_START;
                        x_d      = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        x_d     = 1'b1;
                        tx_en_d = 1'b0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                x_d     = 1'b1;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase

        // abort overrides everything, including a same-cycle handshake
        if (abort && state != S_IDLE) begin
            state_d  = S_IDLE;
            cyc_d    = '0;
            pcnt_d   = '0;
            idx_d    = '0;
            x_d      = 1'b1;
            tx_en_d  = 1'b0;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            strobe_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_fsk_tx_ctrl.sv
// tb_fsk_tx_ctrl: self-checking bench for fsk_tx_ctrl.
// Default build plus a BIT_CYCLES=2, PREAMBLE_BITS=0 build.
`timescale 1ns/1ps
module tb_fsk_tx_ctrl;

    localparam int BC = 40;
    localparam int PB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, abort;
    logic       ready, x_out, tx_en, busy, bit_strobe;
    logic [7:0] data_in;

    logic       rst2, valid2, abort2;
    logic       ready2, x2, tx2, busy2, strobe2;
    logic [7:0] data2;

    fsk_tx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid      (valid),
        .ready      (ready),
        .abort      (abort),
        .x_out      (x_out),
        .tx_en      (tx_en),
        .busy       (busy),
        .bit_strobe (bit_strobe)
    );

    fsk_tx_ctrl #(
        .BIT_CYCLES    (2),
        .PREAMBLE_BITS (0)
    ) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .data_in    (data2),
        .valid      (valid2),
        .ready      (ready2),
        .abort      (abort2),
        .x_out      (x2),
        .tx_en      (tx2),
        .busy       (busy2),
        .bit_strobe (strobe2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard of expected on-air bits
    bit exp_q[$];
    bit cur_bit;
    bit mon_en = 1'b1;
    int run = 0;
    int strobes = 0;
    int hold = 0;
    int last_run = 0;
    int last_strobes = 0;
    int runs_done = 0;

    task automatic push_frame(input logic [7:0] d, input bit pre);
        if (pre) begin
            for (int i = 0; i < PB; i++) exp_q.push_back((i % 2) == 0);
        end
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
    endtask

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            run     = 0;
            strobes = 0;
            hold    = 0;
        end else if (tx_en) begin
            run++;
            if (bit_strobe) begin
                strobes++;
                if (hold != 0) chk("bit_hold", hold, BC);
                hold = 1;
                if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
                else cur_bit = exp_q.pop_front();
            end else begin
                hold++;
            end
            chk("x_out", x_out, cur_bit);
        end else if (run != 0) begin
            chk("last_bit_hold", hold, BC);
            last_run     = run;
            last_strobes = strobes;
            runs_done++;
            run     = 0;
            strobes = 0;
            hold    = 0;
        end
    end

    task automatic send(input logic [7:0] d, input bit pre,
                        output int waited);
        @(negedge clk);
        waited  = 1;
        data_in = d;
        valid   = 1'b1;
        while (!ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            chk("send_timeout", 0, 1);
            valid = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(d, pre);
            #1 valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int r0);
        int n = 0;
        while (runs_done == r0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (runs_done == r0) chk("frame_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_txen"}, tx_en, 0);
        chk({tag, "_x"}, x_out, 1);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         exp_len;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[5];
    bit   samp[20];
    bit   bits2[10];

    initial begin
        int w;
        int r0;
        int n;
        int ns;

        vecs[0] = '{8'hA5, 720, 18};
        vecs[1] = '{8'h00, 720, 18};
        vecs[2] = '{8'hFF, 720, 18};
        vecs[3] = '{8'h3C, 720, 18};
        vecs[4] = '{8'h01, 720, 18};

        rst = 1'b1; valid = 1'b0; abort = 1'b0; data_in = 8'h00;
        rst2 = 1'b1; valid2 = 1'b0; abort2 = 1'b0; data2 = 8'h00;

        repeat (3) begin
            @(negedge clk);
            chk("rst_x", x_out, 1);
            chk("rst_txen", tx_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_strobe", bit_strobe, 0);
            chk("rst_ready", ready, 0);
        end
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ready, 1);
        chk("busy_after_rst", busy, 0);

        // abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", ready, 1);
        chk("idle_abort_busy", busy, 0);

        // single frames from the vector table
        foreach (vecs[i]) begin
            r0 = runs_done;
            send(vecs[i].data, 1'b1, w);
            wait_done(r0);
            chk($sformatf("v%0d_len", i), last_run, vecs[i].exp_len);
            chk($sformatf("v%0d_strobes", i), last_strobes,
                vecs[i].exp_strobes);
            idle_checks($sformatf("v%0d", i));
        end

        // back-to-back: second byte held valid until final STOP cycle
        r0 = runs_done;
        send(8'h00, 1'b1, w);
        send(8'hFF, 1'b0, w);
        chk("b2b_wait", w, 720);
        wait_done(r0);
        chk("b2b_len", last_run, 1120);
        chk("b2b_strobes", last_strobes, 28);
        idle_checks("b2b");

        // backpressure: valid raised mid-DATA is held off until STOP
        r0 = runs_done;
        send(8'h11, 1'b1, w);
        repeat (460) @(negedge clk);
        data_in = 8'h3C;
        valid   = 1'b1;
        chk("bp_ready", ready, 0);
        chk("bp_busy", busy, 1);
        send(8'h3C, 1'b0, w);
        chk("bp_wait", w, 260);
        wait_done(r0);
        chk("bp_len", last_run, 1120);
        chk("bp_strobes", last_strobes, 28);
        idle_checks("bp");

        // abort at DATA bit 3, cyc 17 (cycle 498 of the frame)
        send(8'h5A, 1'b1, w);
        repeat (498) @(negedge clk);
        chk("abort_pre_txen", tx_en, 1);
        chk("abort_pre_x", x_out, 1);
        mon_en = 1'b0;
        abort  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_x", x_out, 1);
        chk("abort_txen", tx_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 1);
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        r0 = runs_done;
        send(8'hC3, 1'b1, w);
        wait_done(r0);
        chk("post_abort_len", last_run, 720);
        chk("post_abort_strobes", last_strobes, 18);
        idle_checks("post_abort");

        // small build: async reset during START
        @(negedge clk);
        chk("d2_ready", ready2, 1);
        data2  = 8'h81;
        valid2 = 1'b1;
        @(posedge clk);
        #1 valid2 = 1'b0;
        @(negedge clk);
        chk("d2_start_x", x2, 0);
        chk("d2_start_txen", tx2, 1);
        chk("d2_start_strobe", strobe2, 1);
        rst2 = 1'b1;
        #1;
        chk("d2_arst_x", x2, 1);
        chk("d2_arst_txen", tx2, 0);
        chk("d2_arst_busy", busy2, 0);
        chk("d2_arst_ready", ready2, 0);
        chk("d2_arst_strobe", strobe2, 0);
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        chk("d2_ready_rec", ready2, 1);
        chk("d2_txen_rec", tx2, 0);

        // small build: 0x81 takes exactly 20 cycles
        bits2[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits2[i+1] = data2[i];
        bits2[9] = 1'b1;
        valid2 = 1'b1;
        @(posedge clk);
        #1 valid2 = 1'b0;
        n  = 0;
        ns = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx2) begin
                if (n < 20) samp[n] = x2;
                if (strobe2) ns++;
                n++;
            end else if (n > 0) begin
                break;
            end
        end
        chk("d2_len", n, 20);
        chk("d2_strobes", ns, 10);
        for (int j = 0; j < 20; j++) begin
            chk($sformatf("d2_x%0d", j), samp[j], bits2[j/2]);
        end
        chk("d2_end_ready", ready2, 1);
        chk("d2_end_busy", busy2, 0);
        chk("d2_end_x", x2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
